// File: rtl/ahblite_uart_slave.sv
// AHB-Lite responder for the UART window: TX/RX byte FIFOs, status register, TX-full wait states.
// Optional: define AHB_UART_ERR_EN to answer offset 0xC with a two-cycle ERROR response.
module ahblite_uart_slave #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL_CNT = (RAW+1)'(RX_DEPTH);
    localparam logic [1:0] A_RXDATA = 2'd0;
    localparam logic [1:0] A_STATE  = 2'd1;
    localparam logic [1:0] A_TXDATA = 2'd2;

    // Size, protection and the upper byte lanes carry no meaning for this block.
    logic unused_ok;
    assign unused_ok = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HWDATA[31:8]};

    logic [1:0] addr_q;
    logic       write_q;
    logic       act_q;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            act_q <= 1'b0;
        end else if (HREADY) begin
            act_q <= HSEL & HTRANS[1];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HREADY) begin
            addr_q  <= HADDR[3:2];
            write_q <= HWRITE;
        end
    end

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wr, tx_rd;
    logic [TAW:0]   tx_count;
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wr, rx_rd;
    logic [RAW:0]   rx_count;
    logic           rx_overrun;

    logic tx_full, tx_empty, rx_full, rx_nonempty;
    logic rd_rx, rd_state, wr_tx, tx_stall, done;
    logic tx_push, tx_pop, rx_push, rx_pop, rx_drop, state_done;

    assign tx_full     = (tx_count == TX_FULL_CNT);
    assign tx_empty    = (tx_count == '0);
    assign rx_full     = (rx_count == RX_FULL_CNT);
    assign rx_nonempty = (rx_count != '0);

    assign rd_rx    = act_q & ~write_q & (addr_q == A_RXDATA);
    assign rd_state = act_q & ~write_q & (addr_q == A_STATE);
    assign wr_tx    = act_q &  write_q & (addr_q == A_TXDATA);
    assign tx_stall = wr_tx & tx_full;

`ifdef AHB_UART_ERR_EN
    localparam logic [1:0] A_UNMAP = 2'd3;
    logic err_acc;
    logic err_ph;
    assign err_acc = act_q & (addr_q == A_UNMAP);

    // err_ph marks the second (ready) cycle of the ERROR response.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            err_ph <= 1'b0;
        end else begin
            err_ph <= err_acc & ~err_ph;
        end
    end

    assign HREADYOUT = ~(tx_stall | (err_acc & ~err_ph));
    assign HRESP     = err_acc;
`else
    assign HREADYOUT = ~tx_stall;
    assign HRESP     = 1'b0;
`endif

    assign done       = act_q & HREADYOUT;
    assign tx_push    = done & wr_tx;
    assign tx_pop     = tx_valid & tx_ready;
    assign rx_pop     = done & rd_rx & rx_nonempty;
    assign rx_push    = rx_valid & (~rx_full | rx_pop);
    assign rx_drop    = rx_valid & rx_full & ~rx_pop;
    assign state_done = done & rd_state;

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rd];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + TAW'(1);
            if (tx_pop)  tx_rd <= tx_rd + TAW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + (TAW+1)'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - (TAW+1)'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (tx_push) tx_mem[tx_wr] <= HWDATA[7:0];
    end

    // A drop in the same cycle as a status read keeps the flag set.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rx_wr      <= '0;
            rx_rd      <= '0;
            rx_count   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + RAW'(1);
            if (rx_pop)  rx_rd <= rx_rd + RAW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + (RAW+1)'(1);
            else if (!rx_push && rx_pop) rx_count <= rx_count - (RAW+1)'(1);
            if (rx_drop)         rx_overrun <= 1'b1;
            else if (state_done) rx_overrun <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (rx_push) rx_mem[rx_wr] <= rx_data;
    end

    always_comb begin
        HRDATA = 32'h0;
        if (act_q && !write_q) begin
            case (addr_q)
                A_RXDATA: if (rx_nonempty) HRDATA = {24'h0, rx_mem[rx_rd]};
                A_STATE:  HRDATA = {28'h0, tx_empty, rx_overrun, rx_nonempty, tx_full};
                default:  HRDATA = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_ahblite_uart_slave.sv
// Self-checking bench for ahblite_uart_slave: queue-based model of the FIFOs and overrun flag.
module tb_ahblite_uart_slave;
    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam logic [31:0] RXA = 32'h4000_0010;
    localparam logic [31:0] STA = 32'h4000_0014;
    localparam logic [31:0] TXA = 32'h4000_0018;
    localparam logic [31:0] UNA = 32'h4000_001C;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = 32'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'b000;
    logic [3:0]  HPROT = 4'h3;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = 32'h0;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         ov;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahblite_uart_slave #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    function automatic logic [31:0] model_state();
        return {28'h0, tx_q.size() == 0, ov, rx_q.size() != 0, tx_q.size() == TXD};
    endfunction

    task automatic bus_idle();
        HSEL = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    // Single non-pipelined transfer; optional rx_valid strobe in the first data-phase cycle.
    task automatic ahb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit rxs, input logic [7:0] rxb,
                            output logic [31:0] rdata, output logic resp,
                            output logic resp_first, output int waits);
        @(negedge HCLK);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HADDR = addr;
        HWRITE = wr;
        @(negedge HCLK);
        bus_idle();
        HWDATA = wdata;
        resp_first = HRESP;
        waits = 0;
        if (rxs) begin
            rx_valid = 1'b1;
            rx_data = rxb;
        end
        while (HREADYOUT !== 1'b1 && waits < 20) begin
            @(negedge HCLK);
            rx_valid = 1'b0;
            waits++;
        end
        if (waits >= 20) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout addr=%h hreadyout=%b required=1", addr, HREADYOUT);
        end
        rdata = HRDATA;
        resp = HRESP;
        @(posedge HCLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic rx_strobe(input logic [7:0] b);
        @(negedge HCLK);
        rx_valid = 1'b1;
        rx_data = b;
        @(negedge HCLK);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_tx_ready();
        tx_ready = 1'b1;
        @(negedge HCLK);
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic rs, rf;
        int w;
        HRESETn = 1'b0;
        bus_idle();
        repeat (3) @(negedge HCLK);
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs hreadyout=%b hresp=%b hrdata=%h tx_valid=%b required 1/0/0/0",
                     HREADYOUT, HRESP, HRDATA, tx_valid);
        end
        HRESETn = 1'b1;
        tx_q.delete();
        rx_q.delete();
        ov = 1'b0;
        ahb_xfer(1'b0, STA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
        checks++;
        if (rd !== 32'h8 || rs !== 1'b0 || w != 0) begin
            errors++;
            $display("FAIL reset_state_read hrdata=%h hresp=%b waits=%0d required 00000008/0/0", rd, rs, w);
        end
    endtask

    task automatic test_tx_basic();
        logic [31:0] rd, wd;
        logic rs, rf;
        int w, n;
        n = $urandom_range(2, TXD);
        for (int i = 0; i < n; i++) begin
            wd = $urandom;
            ahb_xfer(1'b1, TXA, wd, 1'b0, 8'h0, rd, rs, rf, w);
            tx_q.push_back(wd[7:0]);
            checks++;
            if (rs !== 1'b0 || w != 0) begin
                errors++;
                $display("FAIL tx_write_okay hresp=%b waits=%0d required 0/0", rs, w);
            end
        end
        ahb_xfer(1'b0, STA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
        checks++;
        if (rd !== model_state()) begin
            errors++;
            $display("FAIL tx_basic_state hrdata=%h required=%h", rd, model_state());
        end
        @(negedge HCLK);
        while (tx_q.size() > 0) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
                errors++;
                $display("FAIL tx_basic_order tx_valid=%b tx_data=%h required 1/%h", tx_valid, tx_data, tx_q[0]);
            end
            pulse_tx_ready();
            void'(tx_q.pop_front());
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL tx_basic_empty tx_valid=%b required=0", tx_valid);
        end
    endtask

    task automatic test_tx_stall();
        logic [31:0] rd, wd;
        logic rs, rf;
        logic [7:0] b5;
        int w, hold;
        bit stall_ok;
        for (int i = 0; i < TXD; i++) begin
            wd = $urandom;
            ahb_xfer(1'b1, TXA, wd, 1'b0, 8'h0, rd, rs, rf, w);
            tx_q.push_back(wd[7:0]);
        end
        b5 = 8'($urandom);
        @(negedge HCLK);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HADDR = TXA;
        HWRITE = 1'b1;
        @(negedge HCLK);
        bus_idle();
        HWDATA = {24'hABCDEF, b5};
        hold = $urandom_range(1, 4);
        stall_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (HREADYOUT !== 1'b0) stall_ok = 1'b0;
            @(negedge HCLK);
        end
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL tx_stall_hold hreadyout went high during %0d-cycle hold, required 0", hold);
        end
        tx_ready = 1'b1;
        checks++;
        if (HREADYOUT !== 1'b0) begin
            errors++;
            $display("FAIL tx_stall_pop_cycle hreadyout=%b required=0", HREADYOUT);
        end
        @(negedge HCLK);
        tx_ready = 1'b0;
        void'(tx_q.pop_front());
        checks++;
        if (HREADYOUT !== 1'b1 || tx_data !== tx_q[0]) begin
            errors++;
            $display("FAIL tx_stall_release hreadyout=%b tx_data=%h required 1/%h", HREADYOUT, tx_data, tx_q[0]);
        end
        @(posedge HCLK);
        #1;
        tx_q.push_back(b5);
        ahb_xfer(1'b0, STA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
        checks++;
        if (rd !== model_state()) begin
            errors++;
            $display("FAIL tx_stall_state hrdata=%h required=%h", rd, model_state());
        end
        @(negedge HCLK);
        while (tx_q.size() > 0) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
                errors++;
                $display("FAIL tx_stall_order tx_valid=%b tx_data=%h required 1/%h", tx_valid, tx_data, tx_q[0]);
            end
            pulse_tx_ready();
            void'(tx_q.pop_front());
        end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] rd, exp;
        logic rs, rf;
        logic [7:0] b;
        int w, k, nrd;
        k = $urandom_range(3, 7);
        for (int i = 0; i < k; i++) begin
            b = 8'($urandom);
            rx_strobe(b);
            if (rx_q.size() < RXD) rx_q.push_back(b);
            else ov = 1'b1;
        end
        nrd = rx_q.size() + 1;
        for (int i = 0; i < nrd; i++) begin
            ahb_xfer(1'b0, RXA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
            exp = (rx_q.size() > 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
            checks++;
            if (rd !== exp || rs !== 1'b0) begin
                errors++;
                $display("FAIL rx_read_%0d hrdata=%h hresp=%b required %h/0", i, rd, rs, exp);
            end
        end
        for (int i = 0; i < 2; i++) begin
            ahb_xfer(1'b0, STA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
            checks++;
            if (rd !== model_state()) begin
                errors++;
                $display("FAIL rx_overrun_state_%0d hrdata=%h required=%h", i, rd, model_state());
            end
            ov = 1'b0;
        end
    endtask

    task automatic test_rx_edges();
        logic [31:0] rd, exp;
        logic rs, rf;
        logic [7:0] b;
        int w;
        for (int i = 0; i < RXD; i++) begin
            b = 8'($urandom);
            rx_strobe(b);
            rx_q.push_back(b);
        end
        b = 8'($urandom);
        ahb_xfer(1'b0, RXA, 32'h0, 1'b1, b, rd, rs, rf, w);
        exp = {24'h0, rx_q.pop_front()};
        rx_q.push_back(b);
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL rx_full_pop_push hrdata=%h required=%h", rd, exp);
        end
        exp = model_state();
        ahb_xfer(1'b0, STA, 32'h0, 1'b1, 8'($urandom), rd, rs, rf, w);
        ov = 1'b1;
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL rx_state_no_overrun hrdata=%h required=%h", rd, exp);
        end
        ahb_xfer(1'b0, STA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
        checks++;
        if (rd !== model_state()) begin
            errors++;
            $display("FAIL rx_overrun_set_wins hrdata=%h required=%h", rd, model_state());
        end
        ov = 1'b0;
        while (rx_q.size() > 0) begin
            ahb_xfer(1'b0, RXA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
            exp = {24'h0, rx_q.pop_front()};
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("FAIL rx_edges_drain hrdata=%h required=%h", rd, exp);
            end
        end
    endtask

    task automatic test_regmap();
        logic [31:0] rd;
        logic rs, rf;
        logic [7:0] b;
        int w;
        ahb_xfer(1'b0, TXA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
        checks++;
        if (rd !== 32'h0 || rs !== 1'b0 || w != 0) begin
            errors++;
            $display("FAIL txdata_read hrdata=%h hresp=%b waits=%0d required 0/0/0", rd, rs, w);
        end
        b = 8'($urandom);
        rx_strobe(b);
        rx_q.push_back(b);
        ahb_xfer(1'b1, STA, $urandom, 1'b0, 8'h0, rd, rs, rf, w);
        ahb_xfer(1'b1, RXA, $urandom, 1'b0, 8'h0, rd, rs, rf, w);
        checks++;
        if (rs !== 1'b0 || w != 0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL ro_write_okay hresp=%b waits=%0d tx_valid=%b required 0/0/0", rs, w, tx_valid);
        end
        ahb_xfer(1'b0, RXA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
        checks++;
        if (rd !== {24'h0, rx_q[0]}) begin
            errors++;
            $display("FAIL ro_write_no_pop hrdata=%h required=%h", rd, {24'h0, rx_q[0]});
        end
        void'(rx_q.pop_front());
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        logic rs, rf;
        int w;
        ahb_xfer(1'b0, UNA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
`ifdef AHB_UART_ERR_EN
        checks++;
        if (rf !== 1'b1 || rs !== 1'b1 || w != 1) begin
            errors++;
            $display("FAIL unmapped_read_err hresp=%b/%b waits=%0d required 1/1/1", rf, rs, w);
        end
        ahb_xfer(1'b1, UNA, $urandom, 1'b0, 8'h0, rd, rs, rf, w);
        checks++;
        if (rf !== 1'b1 || rs !== 1'b1 || w != 1) begin
            errors++;
            $display("FAIL unmapped_write_err hresp=%b/%b waits=%0d required 1/1/1", rf, rs, w);
        end
`else
        checks++;
        if (rd !== 32'h0 || rs !== 1'b0 || w != 0) begin
            errors++;
            $display("FAIL unmapped_read_okay hrdata=%h hresp=%b waits=%0d required 0/0/0", rd, rs, w);
        end
        ahb_xfer(1'b1, UNA, $urandom, 1'b0, 8'h0, rd, rs, rf, w);
        checks++;
        if (rs !== 1'b0 || w != 0) begin
            errors++;
            $display("FAIL unmapped_write_okay hresp=%b waits=%0d required 0/0", rs, w);
        end
`endif
        ahb_xfer(1'b0, STA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
        checks++;
        if (rd !== model_state() || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_no_effect hrdata=%h tx_valid=%b required %h/0", rd, tx_valid, model_state());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1;
        logic [31:0] d1, d2, e1, e2;
        logic r1, r2;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        @(negedge HCLK);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HADDR = TXA;
        HWRITE = 1'b1;
        @(negedge HCLK);
        HWDATA = {24'h0, b0};
        r1 = HREADYOUT;
        @(negedge HCLK);
        bus_idle();
        HWDATA = {24'h0, b1};
        r2 = HREADYOUT;
        @(posedge HCLK);
        #1;
        tx_q.push_back(b0);
        tx_q.push_back(b1);
        checks++;
        if (r1 !== 1'b1 || r2 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write_ready hreadyout=%b/%b required 1/1", r1, r2);
        end
        @(negedge HCLK);
        while (tx_q.size() > 0) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
                errors++;
                $display("FAIL b2b_tx_order tx_valid=%b tx_data=%h required 1/%h", tx_valid, tx_data, tx_q[0]);
            end
            pulse_tx_ready();
            void'(tx_q.pop_front());
        end
        rx_strobe(b0);
        rx_strobe(b1);
        rx_q.push_back(b0);
        rx_q.push_back(b1);
        @(negedge HCLK);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HADDR = RXA;
        HWRITE = 1'b0;
        @(negedge HCLK);
        d1 = HRDATA;
        @(negedge HCLK);
        bus_idle();
        d2 = HRDATA;
        @(posedge HCLK);
        #1;
        e1 = {24'h0, rx_q.pop_front()};
        e2 = {24'h0, rx_q.pop_front()};
        checks++;
        if (d1 !== e1 || d2 !== e2) begin
            errors++;
            $display("FAIL b2b_rx_reads hrdata=%h/%h required %h/%h", d1, d2, e1, e2);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [31:0] rd, wd;
        logic rs, rf;
        int w;
        for (int i = 0; i < TXD; i++) begin
            wd = $urandom;
            ahb_xfer(1'b1, TXA, wd, 1'b0, 8'h0, rd, rs, rf, w);
        end
        @(negedge HCLK);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HADDR = TXA;
        HWRITE = 1'b1;
        @(negedge HCLK);
        bus_idle();
        HWDATA = $urandom;
        checks++;
        if (HREADYOUT !== 1'b0) begin
            errors++;
            $display("FAIL mid_stall_entry hreadyout=%b required=0", HREADYOUT);
        end
        HRESETn = 1'b0;
        @(negedge HCLK);
        checks++;
        if (HREADYOUT !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stall_reset hreadyout=%b tx_valid=%b required 1/0", HREADYOUT, tx_valid);
        end
        HRESETn = 1'b1;
        tx_q.delete();
        rx_q.delete();
        ov = 1'b0;
        ahb_xfer(1'b0, STA, 32'h0, 1'b0, 8'h0, rd, rs, rf, w);
        checks++;
        if (rd !== 32'h8 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stall_no_push hrdata=%h tx_valid=%b required 00000008/0", rd, tx_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_stall();
        test_rx_overrun();
        test_rx_edges();
        test_regmap();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
